// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package cpu_fetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StDeliver,
    StHold,
    StFault
  } fetch_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Word-aligned instruction addresses only.
  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Request timeout counter: counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT_CYCLES-th enabled cycle is reached.
module fetch_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  // Expiry is combinational so the owner can leave on the last counted cycle.
  assign expired_o = enable_i && !clear_i && (cnt_q == LastCnt);

  // Cycle counter, saturating once expired.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expired_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word reads at the PC, hands each fetched word
// to the instruction register with a one-cycle load pulse, and follows
// sequential fetch or branch redirects. Misaligned redirects stop the unit in a
// sticky fault state until reset.
// Optional build macro FETCH_TIMEOUT_EN adds a request timeout (fault code 10).
module instruction_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        load_en,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  input  logic        fetch_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc_out_q;
  logic         fault_q;
  logic [1:0]   fault_code_q;
  logic         pend_valid_q;
  logic [31:0]  pend_pc_q;

  // A redirect arriving with the ack counts as pending and wins over the latched one.
  logic         redir_any;
  logic [31:0]  redir_tgt;
  assign redir_any = redirect_valid | pend_valid_q;
  assign redir_tgt = redirect_valid ? redirect_pc : pend_pc_q;

`ifdef FETCH_TIMEOUT_EN
  logic timer_clear;
  logic timer_expired;

  // Restart on every entry to REQ, including re-issue after a discarded ack.
  assign timer_clear = (state_q != StReq) | (imem_ack & redir_any);

  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fetch_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .clear_i  (timer_clear),
    .enable_i (state_q == StReq),
    .expired_o(timer_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Fetch sequencer; all outputs are decoded from registered state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      pc_out_q     <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDeliver: begin
          if (redirect_valid) begin
            if (is_aligned(redirect_pc)) begin
              pc_q    <= redirect_pc;
              state_q <= StReq;
            end else begin
              state_q      <= StFault;
              fault_q      <= 1'b1;
              fault_code_q <= FAULT_MISALIGN;
            end
          end else begin
            state_q <= (state_q == StIdle) ? StReq : StHold;
          end
        end

        StReq: begin
          if (imem_ack) begin
            pend_valid_q <= 1'b0;
            if (redir_any) begin
              // Data belongs to the abandoned path; drop it.
              if (is_aligned(redir_tgt)) begin
                pc_q    <= redir_tgt;
                state_q <= StReq;
              end else begin
                state_q      <= StFault;
                fault_q      <= 1'b1;
                fault_code_q <= FAULT_MISALIGN;
              end
            end else begin
              instr_q  <= imem_rdata;
              pc_out_q <= pc_q;
              state_q  <= StDeliver;
            end
          end else begin
            // Hold the request; remember the newest redirect target.
            if (redirect_valid) begin
              pend_valid_q <= 1'b1;
              pend_pc_q    <= redirect_pc;
            end
`ifdef FETCH_TIMEOUT_EN
            if (timer_expired) begin
              state_q      <= StFault;
              fault_q      <= 1'b1;
              fault_code_q <= FAULT_TIMEOUT;
            end
`endif
          end
        end

        StHold: begin
          if (redirect_valid) begin
            if (is_aligned(redirect_pc)) begin
              pc_q    <= redirect_pc;
              state_q <= StReq;
            end else begin
              state_q      <= StFault;
              fault_q      <= 1'b1;
              fault_code_q <= FAULT_MISALIGN;
            end
          end else if (fetch_next) begin
            pc_q    <= pc_q + INSTR_BYTES;
            state_q <= StReq;
          end
        end

        StFault: begin
          state_q <= StFault;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign imem_req        = (state_q == StReq);
  assign imem_addr       = pc_q;
  assign load_en         = (state_q == StDeliver);
  assign instruction_out = instr_q;
  assign pc_out          = pc_out_q;
  assign busy            = (state_q != StHold) && (state_q != StFault);
  assign fault           = fault_q;
  assign fault_code      = fault_code_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        load_en;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        fetch_next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_code;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .load_en        (load_en),
    .instruction_out(instruction_out),
    .pc_out         (pc_out),
    .fetch_next     (fetch_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  // Inputs applied during a cycle and the Moore outputs expected in that cycle.
  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        fn;
    logic        rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        load;
    logic [31:0] instr;
    logic [31:0] pcout;
    logic        busy;
    logic        fault;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic ack, logic [31:0] rdata, logic fn, logic rv,
                              logic [31:0] rpc, logic req, logic [31:0] addr, logic load,
                              logic [31:0] instr, logic [31:0] pcout, logic bsy,
                              logic flt, logic [1:0] code);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.fn = fn; v.rv = rv; v.rpc = rpc;
    v.req = req; v.addr = addr; v.load = load; v.instr = instr; v.pcout = pcout;
    v.busy = bsy; v.fault = flt; v.code = code;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I1 = 32'h0050_0093;
  localparam logic [31:0] IA = 32'hAAAA_0001;
  localparam logic [31:0] I2 = 32'h2222_2222;
  localparam logic [31:0] I3 = 32'h3333_3333;
  localparam logic [31:0] I4 = 32'h4444_4444;
  localparam logic [31:0] I5 = 32'h5555_5555;

  initial begin
    //   rst ack rdata          fn rv rpc            req addr          ld instr pcout   bsy flt cd
    add(1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h0, 32'h0,  1, 0, 2'd0);
    add(0, 1, 32'hCAFEF00D,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0, 32'h0,  1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h0,        0, 32'h0, 32'h0,  1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h0,        0, 32'h0, 32'h0,  1, 0, 2'd0);
    add(0, 1, I1,            0, 0, 32'h0,        1, 32'h0,        0, 32'h0, 32'h0,  1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        1, I1,    32'h0,  1, 0, 2'd0);
    add(0, 0, 32'h0,         1, 0, 32'h0,        0, 32'h0,        0, I1,    32'h0,  0, 0, 2'd0);
    add(0, 1, IA,            0, 0, 32'h0,        1, 32'h4,        0, I1,    32'h0,  1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 1, 32'h100,      0, 32'h4,        1, IA,    32'h4,  1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 1, 32'h200,      1, 32'h100,      0, IA,    32'h4,  1, 0, 2'd0);
    add(0, 1, 32'hDEADBEEF,  0, 0, 32'h0,        1, 32'h100,      0, IA,    32'h4,  1, 0, 2'd0);
    add(0, 1, 32'h11111111,  0, 1, 32'h40,       1, 32'h200,      0, IA,    32'h4,  1, 0, 2'd0);
    add(0, 1, I2,            0, 0, 32'h0,        1, 32'h40,       0, IA,    32'h4,  1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 32'h40,       1, I2,    32'h40, 1, 0, 2'd0);
    add(0, 0, 32'h0,         1, 1, 32'h40,       0, 32'h40,       0, I2,    32'h40, 0, 0, 2'd0);
    add(0, 1, I3,            0, 0, 32'h0,        1, 32'h40,       0, I2,    32'h40, 1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 32'h40,       1, I3,    32'h40, 1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 1, 32'hFFFFFFFC, 0, 32'h40,       0, I3,    32'h40, 0, 0, 2'd0);
    add(0, 1, I4,            0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, I3,    32'h40, 1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 32'hFFFFFFFC, 1, I4, 32'hFFFFFFFC, 1, 0, 2'd0);
    add(0, 0, 32'h0,         1, 0, 32'h0,        0, 32'hFFFFFFFC, 0, I4, 32'hFFFFFFFC, 0, 0, 2'd0);
    add(0, 1, I5,            0, 0, 32'h0,        1, 32'h0,        0, I4, 32'hFFFFFFFC, 1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        1, I5,    32'h0,  1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 1, 32'h102,      0, 32'h0,        0, I5,    32'h0,  0, 0, 2'd0);
    add(0, 1, 32'h66666666,  1, 1, 32'h200,      0, 32'h0,        0, I5,    32'h0,  0, 1, 2'd1);
    add(0, 1, 32'h66666666,  0, 0, 32'h0,        0, 32'h0,        0, I5,    32'h0,  0, 1, 2'd1);
    add(1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, I5,    32'h0,  0, 1, 2'd1);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h0, 32'h0,  1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 1, 32'h3,        1, 32'h0,        0, 32'h0, 32'h0,  1, 0, 2'd0);
    add(0, 1, 32'h77777777,  0, 0, 32'h0,        1, 32'h0,        0, 32'h0, 32'h0,  1, 0, 2'd0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h0, 32'h0,  0, 1, 2'd1);
    add(1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h0, 32'h0,  0, 1, 2'd1);

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    fetch_next = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) step();

    // Check this cycle's outputs, then drive this cycle's inputs.
    foreach (vecs[i]) begin
      chk($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vecs[i].req));
      chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("row%0d load_en", i), 32'(load_en), 32'(vecs[i].load));
      chk($sformatf("row%0d instruction_out", i), instruction_out, vecs[i].instr);
      chk($sformatf("row%0d pc_out", i), pc_out, vecs[i].pcout);
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("row%0d fault", i), 32'(fault), 32'(vecs[i].fault));
      chk($sformatf("row%0d fault_code", i), 32'(fault_code), 32'(vecs[i].code));
      reset          = vecs[i].rst;
      imem_ack       = vecs[i].ack;
      imem_rdata     = vecs[i].rdata;
      fetch_next     = vecs[i].fn;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      step();
    end

    // Ack held across reset release is ignored: first REQ, not DELIVER.
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h9999_9999;
    step();
    chk("post-reset ack ignored req", 32'(imem_req), 32'd1);
    chk("post-reset ack ignored load", 32'(load_en), 32'd0);
    imem_ack = 1'b0;

    // Reset asserted mid-request drops the request without waiting for a clock.
    #2 reset = 1'b1;
    #1;
    chk("async reset drops req", 32'(imem_req), 32'd0);
    chk("async reset busy", 32'(busy), 32'd1);
    step();
    reset = 1'b0;
    chk("idle after reset", 32'(imem_req), 32'd0);

    // Request with no ack: four REQ cycles, then timeout or keep waiting.
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("no-ack REQ cycle %0d", c), 32'(imem_req), 32'd1);
    end
    step();
`ifdef FETCH_TIMEOUT_EN
    chk("timeout req dropped", 32'(imem_req), 32'd0);
    chk("timeout fault", 32'(fault), 32'd1);
    chk("timeout fault_code", 32'(fault_code), 32'd2);
    chk("timeout busy", 32'(busy), 32'd0);
`else
    chk("no timeout req held", 32'(imem_req), 32'd1);
    chk("no timeout fault", 32'(fault), 32'd0);
    repeat (20) step();
    chk("long wait req held", 32'(imem_req), 32'd1);
    chk("long wait fault_code", 32'(fault_code), 32'd0);
    chk("long wait addr", imem_addr, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have a parameter RESET_PC, default 32'h00000000: PC loaded on reset; bits [1:0] are zero.
REQ-002 The block SHALL have a parameter TIMEOUT_CYCLES, default 16: maximum REQ cycles without imem_ack; used only with FETCH_TIMEOUT_EN.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 imem_req  out  1  instruction-memory read request.
REQ-007 imem_addr  out  32  read address, equal to the current PC.
REQ-008 imem_ack  in  1  memory response valid; qualifies imem_rdata.
REQ-009 imem_rdata  in  32  fetched instruction word.
REQ-010 load_en  out  1  one-cycle pulse to the instruction register.
REQ-011 instruction_out  out  32  fetched word, feeding the instruction register input.
REQ-012 pc_out  out  32  address of the word on instruction_out.
REQ-013 fetch_next  in  1  consumer is done with the current word; fetch the next one.
REQ-014 redirect_valid  in  1  branch/jump redirect strobe.
REQ-015 redirect_pc  in  32  redirect target.
REQ-016 busy  out  1  high in every state except HOLD and FAULT.
REQ-017 fault  out  1  sticky fault flag.
REQ-018 fault_code  out  2  00 none, 01 misaligned redirect, 10 timeout.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, DELIVER, HOLD and FAULT; its outputs SHALL be Moore outputs: imem_req = (state==REQ), load_en = (state==DELIVER), imem_addr = pc.
REQ-020 From IDLE, the FSM SHALL move to REQ on the next clock, unconditionally.
REQ-021 In REQ, imem_req and imem_addr SHALL stay stable until imem_ack is sampled high; a request SHALL never be withdrawn before its ack.
REQ-022 On an imem_ack sampled high in REQ, the block SHALL capture imem_rdata into instruction_out and pc into pc_out, and move to DELIVER.
REQ-023 load_en SHALL be high for exactly one cycle, in the cycle after the ack; instruction_out SHALL be valid then and held until the next capture.
REQ-024 From DELIVER, the FSM SHALL move to HOLD.
REQ-025 In HOLD, on fetch_next, the block SHALL set pc <= pc + 4 and move to REQ, so imem_req is high in the next cycle.
REQ-026 pc + 4 SHALL wrap modulo 2^32: 32'hFFFFFFFC -> 32'h00000000, with no fault.
REQ-027 An aligned redirect in IDLE, DELIVER or HOLD SHALL set pc <= redirect_pc and move to REQ; if it coincides with load_en, the pulse still completes.
REQ-028 An aligned redirect in REQ SHALL be latched as pending and the request held; the ack's data SHALL be discarded (no capture, no load_en); then pc <= target and the FSM moves to REQ.
REQ-029 A redirect in the same cycle as the ack SHALL be treated as pending per REQ-028.
REQ-030 redirect_valid SHALL take priority over fetch_next when both are high.
REQ-031 A later redirect SHALL overwrite a pending target.
REQ-032 A redirect with redirect_pc[1:0] != 0 SHALL move the FSM to FAULT with fault=1 and fault_code=01; if it arrives in REQ, the move to FAULT happens on the ack.
REQ-033 In FAULT, imem_req and load_en SHALL be 0, all inputs SHALL be ignored, and the only exit SHALL be reset.

Reset
REQ-034 Reset SHALL asynchronously set: state=IDLE, pc=RESET_PC, instruction_out=0, pc_out=0, fault=0, fault_code=00, pending redirect cleared, timer=0.
REQ-035 Reset asserted mid-request SHALL abandon the request immediately; an ack arriving after reset is released and before the first REQ SHALL be ignored.

Configuration
REQ-036 The macro FETCH_TIMEOUT_EN SHALL control the request timeout.
REQ-037 With FETCH_TIMEOUT_EN defined, a counter SHALL clear on entry to REQ and count REQ cycles.
REQ-038 With FETCH_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without an ack SHALL move the FSM to FAULT with fault_code=10.
REQ-039 Without FETCH_TIMEOUT_EN, REQ SHALL wait indefinitely, no counter logic SHALL exist, and fault_code SHALL never be 10.

Structure
REQ-040 Package cpu_fetch_pkg SHALL hold the state enum, the fault-code constants (FAULT_NONE, FAULT_MISALIGN, FAULT_TIMEOUT) and INSTR_BYTES=4.
REQ-041 One sub-module, fetch_timer (clear, enable, expired output; parameter TIMEOUT_CYCLES), SHALL be instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-042 Reset release, ack after 2 cycles with rdata=32'h00500093 -> imem_addr=0; load_en pulses once; instruction_out=32'h00500093; pc_out=0; busy=0 in HOLD.
REQ-043 fetch_next in HOLD with pc=32'hFFFFFFFC -> next imem_addr=32'h00000000; fault stays 0.
REQ-044 Redirect to 32'h00000100 during REQ, ack one cycle later -> no load_en for that data; next imem_addr=32'h100.
REQ-045 redirect_valid and fetch_next together in HOLD, redirect_pc=32'h40 -> imem_addr=32'h40, not pc+4.
REQ-046 redirect_pc=32'h00000102 -> fault=1, fault_code=01, imem_req stays 0 until reset.
REQ-047 With FETCH_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, no ack -> FAULT after 4 REQ cycles, fault_code=10; without the macro, the same stimulus -> the block waits in REQ indefinitely.
